// File: rtl/tmds_channel_decoder.sv
// Per-channel HDMI TMDS receive decoder: classifies each aligned 10-bit symbol into
// its HDMI period (control, video guard, video, island guard, island) and decodes it.
module tmds_channel_decoder #(
  parameter int CN = 0
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] tmds,
  input  logic       island_next,
  output logic [7:0] video_data,
  output logic [1:0] control_data,
  output logic [3:0] data_island_data,
  output logic [2:0] mode,
  output logic       symbol_err
);

  localparam logic [2:0] MODE_CTRL   = 3'd0;
  localparam logic [2:0] MODE_VIDEO  = 3'd1;
  localparam logic [2:0] MODE_VGUARD = 3'd2;
  localparam logic [2:0] MODE_ISLAND = 3'd3;
  localparam logic [2:0] MODE_IGUARD = 3'd4;

  localparam logic [9:0] VGUARD_CODE = (CN == 1) ? 10'b0100110011 : 10'b1011001100;
  localparam logic [9:0] DGUARD_CODE = 10'b0100110011;
  localparam logic [9:0] PCNT_MAX    = 10'd576;

  typedef enum logic [2:0] {
    S_CTRL   = 3'd0,
    S_VLEAD  = 3'd1,
    S_VIDEO  = 3'd2,
    S_ILEAD  = 3'd3,
    S_ISLAND = 3'd4,
    S_TRAIL  = 3'd5
  } state_t;

  // Stage 1: input capture
  logic [9:0] tmds_q;
  logic       isl1_q;
  logic       vld1_q;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      tmds_q <= '0;
      isl1_q <= 1'b0;
      vld1_q <= 1'b0;
    end else begin
      tmds_q <= tmds;
      isl1_q <= island_next;
      vld1_q <= 1'b1;
    end
  end

  // Stage 2: symbol classification and field decode
  logic       ctrl_hit_d, terc_hit_d, vguard_d, dguard_d;
  logic [1:0] ctrl_val_d;
  logic [3:0] terc_val_d;
  logic [7:0] vid_d, q_pol;

  always_comb begin
    ctrl_hit_d = 1'b1;
    ctrl_val_d = 2'b00;
    case (tmds_q)
      10'b1101010100: ctrl_val_d = 2'b00;
      10'b0010101011: ctrl_val_d = 2'b01;
      10'b0101010100: ctrl_val_d = 2'b10;
      10'b1010101011: ctrl_val_d = 2'b11;
      default:        ctrl_hit_d = 1'b0;
    endcase

    terc_hit_d = 1'b1;
    terc_val_d = 4'h0;
    case (tmds_q)
      10'b1010011100: terc_val_d = 4'h0;
      10'b1001100011: terc_val_d = 4'h1;
      10'b1011100100: terc_val_d = 4'h2;
      10'b1011100010: terc_val_d = 4'h3;
      10'b0101110001: terc_val_d = 4'h4;
      10'b0100011110: terc_val_d = 4'h5;
      10'b0110001110: terc_val_d = 4'h6;
      10'b0100111100: terc_val_d = 4'h7;
      10'b1011001100: terc_val_d = 4'h8;
      10'b0100111001: terc_val_d = 4'h9;
      10'b0110011100: terc_val_d = 4'hA;
      10'b1011000110: terc_val_d = 4'hB;
      10'b1010001110: terc_val_d = 4'hC;
      10'b1001110001: terc_val_d = 4'hD;
      10'b0101100011: terc_val_d = 4'hE;
      10'b1011000011: terc_val_d = 4'hF;
      default:        terc_hit_d = 1'b0;
    endcase

    vguard_d = (tmds_q == VGUARD_CODE);
    // Channel 0 carries hsync/vsync inside its island guard, so any TERC4 11xx code is a guard.
    if (CN == 0) begin
      dguard_d = terc_hit_d && (terc_val_d[3:2] == 2'b11);
    end else begin
      dguard_d = (tmds_q == DGUARD_CODE);
    end
  end

  assign q_pol    = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
  assign vid_d[0] = q_pol[0];
  for (genvar gi = 1; gi < 8; gi++) begin : g_vid
    assign vid_d[gi] = tmds_q[8] ? (q_pol[gi] ^ q_pol[gi-1]) : ~(q_pol[gi] ^ q_pol[gi-1]);
  end

  logic       ctrl_hit_q, terc_hit_q, vguard_q, dguard_q, isl2_q, vld2_q;
  logic [1:0] ctrl_val_q;
  logic [3:0] terc_val_q;
  logic [7:0] vid_q;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      ctrl_hit_q <= 1'b0;
      terc_hit_q <= 1'b0;
      vguard_q   <= 1'b0;
      dguard_q   <= 1'b0;
      isl2_q     <= 1'b0;
      vld2_q     <= 1'b0;
      ctrl_val_q <= '0;
      terc_val_q <= '0;
      vid_q      <= '0;
    end else begin
      ctrl_hit_q <= ctrl_hit_d;
      terc_hit_q <= terc_hit_d;
      vguard_q   <= vguard_d;
      dguard_q   <= dguard_d;
      isl2_q     <= isl1_q;
      vld2_q     <= vld1_q;
      ctrl_val_q <= ctrl_val_d;
      terc_val_q <= terc_val_d;
      vid_q      <= vid_d;
    end
  end

  // Stage 3: period FSM, then registered output formatting
  state_t     state_q, state_d;
  logic [9:0] pcnt_q, pcnt_d;
  logic [2:0] sym_mode_q, sym_mode_d;
  logic       sym_err_q, sym_err_d;
  logic       sym_ctl_ok_q, sym_ctl_ok_d;
  logic [1:0] sym_ctrl_val_q;
  logic       sym_terc_hit_q;
  logic [3:0] sym_terc_val_q;
  logic [7:0] sym_vid_q;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q        <= S_CTRL;
      pcnt_q         <= '0;
      sym_mode_q     <= MODE_CTRL;
      sym_err_q      <= 1'b0;
      sym_ctl_ok_q   <= 1'b0;
      sym_ctrl_val_q <= '0;
      sym_terc_hit_q <= 1'b0;
      sym_terc_val_q <= '0;
      sym_vid_q      <= '0;
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      sym_mode_q     <= sym_mode_d;
      sym_err_q      <= sym_err_d;
      sym_ctl_ok_q   <= sym_ctl_ok_d;
      sym_ctrl_val_q <= ctrl_val_q;
      sym_terc_hit_q <= terc_hit_q;
      sym_terc_val_q <= terc_val_q;
      sym_vid_q      <= vid_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    sym_mode_d   = MODE_CTRL;
    sym_err_d    = 1'b0;
    sym_ctl_ok_d = 1'b0;
    // Slots still holding reset-cleared pipeline contents produce neutral output.
    if (vld2_q) begin
      case (state_q)
        S_CTRL: begin
          if (ctrl_hit_q) begin
            sym_ctl_ok_d = 1'b1;
          end else if (dguard_q && isl2_q) begin
            state_d    = S_ILEAD;
            sym_mode_d = MODE_IGUARD;
          end else if (vguard_q && !isl2_q) begin
            state_d    = S_VLEAD;
            sym_mode_d = MODE_VGUARD;
          end else begin
            sym_err_d = 1'b1;
          end
        end
        S_VLEAD: begin
          if (vguard_q) begin
            state_d    = S_VIDEO;
            sym_mode_d = MODE_VGUARD;
          end else begin
            state_d   = S_CTRL;
            sym_err_d = 1'b1;
          end
        end
        S_VIDEO: begin
          if (ctrl_hit_q) begin
            state_d      = S_CTRL;
            sym_ctl_ok_d = 1'b1;
          end else begin
            sym_mode_d = MODE_VIDEO;
          end
        end
        S_ILEAD: begin
          if (dguard_q) begin
            state_d    = S_ISLAND;
            sym_mode_d = MODE_IGUARD;
            pcnt_d     = '0;
          end else begin
            state_d   = S_CTRL;
            sym_err_d = 1'b1;
          end
        end
        S_ISLAND: begin
          pcnt_d = pcnt_q + 10'd1;
          if ((pcnt_q != 10'd0) && (pcnt_q[4:0] == 5'd0) && dguard_q) begin
            state_d    = S_TRAIL;
            sym_mode_d = MODE_IGUARD;
          end else if (pcnt_q >= PCNT_MAX) begin
            state_d   = S_CTRL;
            sym_err_d = 1'b1;
            pcnt_d    = '0;
          end else begin
            sym_mode_d = MODE_ISLAND;
            sym_err_d  = !terc_hit_q;
          end
        end
        S_TRAIL: begin
          state_d    = S_CTRL;
          sym_mode_d = MODE_IGUARD;
          sym_err_d  = !dguard_q;
        end
        default: state_d = S_CTRL;
      endcase
    end
  end

  logic [7:0] video_data_q, video_data_d;
  logic [1:0] control_data_q, control_data_d;
  logic [3:0] island_data_q, island_data_d;
  logic [2:0] mode_q, mode_d;
  logic       symbol_err_q, symbol_err_d;

  always_comb begin
    mode_d         = sym_mode_q;
    symbol_err_d   = sym_err_q;
    video_data_d   = (sym_mode_q == MODE_VIDEO) ? sym_vid_q : 8'h00;
    island_data_d  = ((sym_mode_q == MODE_ISLAND) && sym_terc_hit_q) ? sym_terc_val_q : 4'h0;
    control_data_d = 2'b00;
    if (sym_mode_q == MODE_CTRL) begin
      control_data_d = sym_ctl_ok_q ? sym_ctrl_val_q : control_data_q;
    end else if ((sym_mode_q == MODE_IGUARD) && (CN == 0)) begin
      control_data_d = sym_terc_val_q[1:0];
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      video_data_q   <= '0;
      control_data_q <= '0;
      island_data_q  <= '0;
      mode_q         <= MODE_CTRL;
      symbol_err_q   <= 1'b0;
    end else begin
      video_data_q   <= video_data_d;
      control_data_q <= control_data_d;
      island_data_q  <= island_data_d;
      mode_q         <= mode_d;
      symbol_err_q   <= symbol_err_d;
    end
  end

  assign video_data       = video_data_q;
  assign control_data     = control_data_q;
  assign data_island_data = island_data_q;
  assign mode             = mode_q;
  assign symbol_err       = symbol_err_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench for tmds_channel_decoder: channel 0 and channel 1 instances,
// directed symbols with hand-derived expectations checked 3 edges after sampling.
module tb_tmds_channel_decoder;

  localparam logic [9:0] CTL00 = 10'b1101010100;
  localparam logic [9:0] CTL01 = 10'b0010101011;
  localparam logic [9:0] CTL10 = 10'b0101010100;
  localparam logic [9:0] CTL11 = 10'b1010101011;
  localparam logic [9:0] VG0   = 10'b1011001100;
  localparam logic [9:0] DG0   = 10'b1011000011;
  localparam logic [9:0] G1    = 10'b0100110011;
  localparam logic [2:0] M_C = 3'd0, M_V = 3'd1, M_VG = 3'd2, M_IS = 3'd3, M_IG = 3'd4;

  typedef struct {
    int         due;
    int         tag;
    logic [2:0] mode;
    logic       err;
    logic [7:0] vid;
    logic [1:0] ctl;
    logic [3:0] nib;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] tmds0, tmds1;
  logic       isl0, isl1;
  logic [7:0] vid0, vid1;
  logic [1:0] ctl0, ctl1;
  logic [3:0] nib0, nib1;
  logic [2:0] mode0, mode1;
  logic       err0, err1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   tag_cnt = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t x0, x1;
  logic [9:0] terc_tab [16];

  tmds_channel_decoder #(.CN(0)) dut0 (
    .clk_pixel(clk), .reset(rst), .tmds(tmds0), .island_next(isl0),
    .video_data(vid0), .control_data(ctl0), .data_island_data(nib0),
    .mode(mode0), .symbol_err(err0)
  );

  tmds_channel_decoder #(.CN(1)) dut1 (
    .clk_pixel(clk), .reset(rst), .tmds(tmds1), .island_next(isl1),
    .video_data(vid1), .control_data(ctl1), .data_island_data(nib1),
    .mode(mode1), .symbol_err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check_one(input int dut, input exp_t x, input logic [2:0] m,
                                    input logic e, input logic [7:0] v, input logic [1:0] c,
                                    input logic [3:0] n);
    checks++;
    if (x.due != cyc || m !== x.mode || e !== x.err || v !== x.vid || c !== x.ctl || n !== x.nib) begin
      errors++;
      $display("FAIL sb dut%0d #%0d cyc %0d: got mode=%0d err=%0b vid=%h ctl=%b nib=%h, need mode=%0d err=%0b vid=%h ctl=%b nib=%h due %0d",
               dut, x.tag, cyc, m, e, v, c, n, x.mode, x.err, x.vid, x.ctl, x.nib, x.due);
    end else begin
      $display("txn dut%0d #%0d mode=%0d err=%0b vid=%h ctl=%b nib=%h ok", dut, x.tag, m, e, v, c, n);
    end
  endfunction

  // Monitor: pops whatever expectation falls due on this cycle.
  always @(negedge clk) begin
    if (q0.size() > 0 && q0[0].due <= cyc) begin
      x0 = q0.pop_front();
      check_one(0, x0, mode0, err0, vid0, ctl0, nib0);
    end
    if (q1.size() > 0 && q1[0].due <= cyc) begin
      x1 = q1.pop_front();
      check_one(1, x1, mode1, err1, vid1, ctl1, nib1);
    end
  end

  task automatic push_exp(input int dut, input int due, input logic [2:0] m, input logic e,
                          input logic [7:0] v, input logic [1:0] c, input logic [3:0] n);
    exp_t x;
    x.due = due; x.tag = tag_cnt; x.mode = m; x.err = e; x.vid = v; x.ctl = c; x.nib = n;
    tag_cnt++;
    if (dut == 0) q0.push_back(x);
    else q1.push_back(x);
  endtask

  task automatic send(input int dut, input logic [9:0] sym, input logic isl, input bit chk,
                      input logic [2:0] m, input logic e, input logic [7:0] v,
                      input logic [1:0] c, input logic [3:0] n);
    @(posedge clk);
    #1;
    if (dut == 0) begin tmds0 = sym; isl0 = isl; end
    else begin tmds1 = sym; isl1 = isl; end
    if (chk) push_exp(dut, cyc + 4, m, e, v, c, n);
  endtask

  task automatic island_seq(input int dut, input logic [9:0] guard, input int bad,
                            input logic [1:0] gctl);
    logic [3:0] nib;
    send(dut, guard, 1'b1, 1'b1, M_IG, 1'b0, 8'h00, gctl, 4'h0);
    send(dut, guard, 1'b0, 1'b1, M_IG, 1'b0, 8'h00, gctl, 4'h0);
    for (int i = 0; i < 32; i++) begin
      nib = i[3:0];
      if (i == bad) send(dut, 10'b1111111111, 1'b0, 1'b1, M_IS, 1'b1, 8'h00, 2'b00, 4'h0);
      else send(dut, terc_tab[nib], 1'b0, 1'b1, M_IS, 1'b0, 8'h00, 2'b00, nib);
    end
    send(dut, guard, 1'b0, 1'b1, M_IG, 1'b0, 8'h00, gctl, 4'h0);
    send(dut, guard, 1'b0, 1'b1, M_IG, 1'b0, 8'h00, gctl, 4'h0);
    send(dut, CTL00, 1'b0, 1'b1, M_C, 1'b0, 8'h00, 2'b00, 4'h0);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (mode0 !== 3'd0 || err0 !== 1'b0 || vid0 !== 8'h00 || ctl0 !== 2'b00 || nib0 !== 4'h0) begin
      errors++;
      $display("FAIL %s: got mode=%0d err=%0b vid=%h ctl=%b nib=%h, need all zero",
               name, mode0, err0, vid0, ctl0, nib0);
    end else begin
      $display("txn %s all zero ok", name);
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 20 && (q0.size() + q1.size()) > 0; k++) @(posedge clk);
    @(negedge clk);
    checks++;
    if ((q0.size() + q1.size()) != 0) begin
      errors++;
      $display("FAIL %s: %0d expectations never came due, need 0", name, q0.size() + q1.size());
    end
  endtask

  initial begin
    terc_tab = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                 10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                 10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                 10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    rst = 1'b1; tmds0 = CTL11; tmds1 = CTL00; isl0 = 1'b0; isl1 = 1'b0;
    repeat (3) @(posedge clk);
    #3 check_zero("reset_state");

    // Release: three cleared output slots, then the held CTL11 symbol.
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) push_exp(0, cyc + k, M_C, 1'b0, 8'h00, 2'b00, 4'h0);
    push_exp(0, cyc + 4, M_C, 1'b0, 8'h00, 2'b11, 4'h0);

    // Control codes, then a junk symbol that must hold the last control value.
    send(0, CTL00, 1'b0, 1'b1, M_C, 1'b0, 8'h00, 2'b00, 4'h0);
    send(0, CTL01, 1'b0, 1'b1, M_C, 1'b0, 8'h00, 2'b01, 4'h0);
    send(0, CTL10, 1'b0, 1'b1, M_C, 1'b0, 8'h00, 2'b10, 4'h0);
    send(0, CTL11, 1'b0, 1'b1, M_C, 1'b0, 8'h00, 2'b11, 4'h0);
    send(0, 10'b1111100000, 1'b0, 1'b1, M_C, 1'b1, 8'h00, 2'b11, 4'h0);
    send(0, CTL00, 1'b0, 1'b1, M_C, 1'b0, 8'h00, 2'b00, 4'h0);

    // Video period on channel 0.
    send(0, VG0, 1'b0, 1'b1, M_VG, 1'b0, 8'h00, 2'b00, 4'h0);
    send(0, VG0, 1'b0, 1'b1, M_VG, 1'b0, 8'h00, 2'b00, 4'h0);
    send(0, 10'b0100000000, 1'b0, 1'b1, M_V, 1'b0, 8'h00, 2'b00, 4'h0);
    send(0, 10'b1000000000, 1'b0, 1'b1, M_V, 1'b0, 8'hFF, 2'b00, 4'h0);
    send(0, 10'b0111111111, 1'b0, 1'b1, M_V, 1'b0, 8'h01, 2'b00, 4'h0);
    send(0, VG0, 1'b0, 1'b1, M_V, 1'b0, 8'hAB, 2'b00, 4'h0);
    send(0, CTL00, 1'b0, 1'b1, M_C, 1'b0, 8'h00, 2'b00, 4'h0);

    // Data islands: clean, then one corrupted symbol, then channel 1.
    island_seq(0, DG0, -1, 2'b11);
    island_seq(0, DG0, 5, 2'b11);
    island_seq(1, G1, -1, 2'b00);

    // Channel 1 video guard followed by a non-guard: error, back to control.
    send(1, G1, 1'b0, 1'b1, M_VG, 1'b0, 8'h00, 2'b00, 4'h0);
    send(1, CTL00, 1'b0, 1'b1, M_C, 1'b1, 8'h00, 2'b00, 4'h0);
    send(1, CTL11, 1'b0, 1'b1, M_C, 1'b0, 8'h00, 2'b11, 4'h0);
    drain("drain_main");

    // Asynchronous reset in the middle of video.
    send(0, VG0, 1'b0, 1'b0, M_C, 1'b0, 8'h00, 2'b00, 4'h0);
    send(0, VG0, 1'b0, 1'b0, M_C, 1'b0, 8'h00, 2'b00, 4'h0);
    for (int k = 0; k < 4; k++) send(0, 10'b0100000000, 1'b0, 1'b0, M_C, 1'b0, 8'h00, 2'b00, 4'h0);
    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (mode0 !== M_V) begin
      errors++;
      $display("FAIL pre_reset_mode: got %0d, need %0d", mode0, M_V);
    end
    rst = 1'b1;
    #1 check_zero("async_reset");
    tmds0 = CTL01;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    send(0, CTL01, 1'b0, 1'b1, M_C, 1'b0, 8'h00, 2'b01, 4'h0);
    send(0, CTL10, 1'b0, 1'b1, M_C, 1'b0, 8'h00, 2'b10, 4'h0);
    send(0, CTL00, 1'b0, 1'b1, M_C, 1'b0, 8'h00, 2'b00, 4'h0);
    drain("drain_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
